// File: rtl/sram_bus_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave arbiter for the shared
// SRAM AXI4-Lite-style bus. Exactly one transaction is outstanding at a time; the
// grant is held from address handshake to response handshake and every channel of
// the granted master is passed straight through to the slave port.
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,

    // IFU read master
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,

    // LSU read/write master
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    output logic [1:0]            lsu_bresp,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,

    // SRAM / SoC slave port
    output logic [ADDR_W-1:0]     sram_araddr,
    output logic                  sram_arvalid,
    input  logic                  sram_arready,
    input  logic [DATA_W-1:0]     sram_rdata,
    input  logic [1:0]            sram_rresp,
    input  logic                  sram_rvalid,
    output logic                  sram_rready,
    output logic [ADDR_W-1:0]     sram_awaddr,
    output logic                  sram_awvalid,
    input  logic                  sram_awready,
    output logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W/8-1:0]   sram_wstrb,
    output logic                  sram_wvalid,
    input  logic                  sram_wready,
    input  logic [1:0]            sram_bresp,
    input  logic                  sram_bvalid,
    output logic                  sram_bready,

    // Debug: 00 none, 01 IFU read, 10 LSU read, 11 LSU write
    output logic [1:0]            grant
);

    // Encoding doubles as the debug grant value.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIfuRd = 2'b01,
        StLsuRd = 2'b10,
        StLsuWr = 2'b11
    } state_e;

    state_e state_q, state_d;
    // 1 when the LSU received the most recent grant; used for round-robin ties.
    logic   last_lsu_q, last_lsu_d;
    logic   lsu_req;
    logic   lsu_wins;

    assign lsu_req = lsu_arvalid | lsu_awvalid;
    // LSU takes the bus when alone, under fixed priority, or when IFU was served last.
    assign lsu_wins = lsu_req && (!ifu_arvalid || !RR_EN || !last_lsu_q);

    // State and round-robin history registers; reset leaves LSU winning the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            last_lsu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
        end
    end

    // Next state: arbitrate in idle, hold the grant until the response handshake.
    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        unique case (state_q)
            StIdle: begin
                if (lsu_wins) begin
                    // A read and a write from the LSU together: the read goes first.
                    state_d    = lsu_arvalid ? StLsuRd : StLsuWr;
                    last_lsu_d = 1'b1;
                end else if (ifu_arvalid) begin
                    state_d    = StIfuRd;
                    last_lsu_d = 1'b0;
                end
            end
            StIfuRd: begin
                if (sram_rvalid && ifu_rready) state_d = StIdle;
            end
            StLsuRd: begin
                if (sram_rvalid && lsu_rready) state_d = StIdle;
            end
            StLsuWr: begin
                if (sram_bvalid && lsu_bready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Channel routing: pure pass-through for the granted master, everything else zero.
    always_comb begin
        ifu_arready  = 1'b0;
        ifu_rdata    = '0;
        ifu_rresp    = '0;
        ifu_rvalid   = 1'b0;
        lsu_arready  = 1'b0;
        lsu_rdata    = '0;
        lsu_rresp    = '0;
        lsu_rvalid   = 1'b0;
        lsu_awready  = 1'b0;
        lsu_wready   = 1'b0;
        lsu_bresp    = '0;
        lsu_bvalid   = 1'b0;
        sram_araddr  = '0;
        sram_arvalid = 1'b0;
        sram_rready  = 1'b0;
        sram_awaddr  = '0;
        sram_awvalid = 1'b0;
        sram_wdata   = '0;
        sram_wstrb   = '0;
        sram_wvalid  = 1'b0;
        sram_bready  = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StIfuRd: begin
                sram_araddr  = ifu_araddr;
                sram_arvalid = ifu_arvalid;
                ifu_arready  = sram_arready;
                ifu_rdata    = sram_rdata;
                ifu_rresp    = sram_rresp;
                ifu_rvalid   = sram_rvalid;
                sram_rready  = ifu_rready;
            end
            StLsuRd: begin
                sram_araddr  = lsu_araddr;
                sram_arvalid = lsu_arvalid;
                lsu_arready  = sram_arready;
                lsu_rdata    = sram_rdata;
                lsu_rresp    = sram_rresp;
                lsu_rvalid   = sram_rvalid;
                sram_rready  = lsu_rready;
            end
            StLsuWr: begin
                // AW and W are independent; either may complete first.
                sram_awaddr  = lsu_awaddr;
                sram_awvalid = lsu_awvalid;
                lsu_awready  = sram_awready;
                sram_wdata   = lsu_wdata;
                sram_wstrb   = lsu_wstrb;
                sram_wvalid  = lsu_wvalid;
                lsu_wready   = sram_wready;
                lsu_bresp    = sram_bresp;
                lsu_bvalid   = sram_bvalid;
                sram_bready  = lsu_bready;
            end
            default: begin
            end
        endcase
    end

    assign grant = state_q;

`ifndef SYNTHESIS
    // No slave-side handshake may complete while nothing is granted.
    a_idle_quiet: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StIdle) |-> !((sram_arvalid && sram_arready) ||
                                  (sram_rvalid  && sram_rready)  ||
                                  (sram_awvalid && sram_awready) ||
                                  (sram_wvalid  && sram_wready)  ||
                                  (sram_bvalid  && sram_bready)));

    // Write grant never completes a read response.
    a_no_r_in_wr: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StLsuWr) |-> !(sram_rvalid && sram_rready));

    // Read grants never complete a write response.
    a_no_b_in_rd: assert property (@(posedge clk) disable iff (!reset)
        ((state_q == StIfuRd) || (state_q == StLsuRd)) |-> !(sram_bvalid && sram_bready));
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: a round-robin and a fixed-priority instance share all
// inputs. A vector table covers the per-cycle handshake/grant behaviour; hand-written
// sequences cover data routing, error responses, stalls and mid-transaction reset.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, sram_rdata;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  sram_rresp, sram_bresp;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_awvalid;
    logic        lsu_wvalid, lsu_bready, sram_arready, sram_rvalid, sram_awready;
    logic        sram_wready, sram_bvalid;

    // Round-robin instance outputs
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready;
    logic        lsu_wready, lsu_bvalid, sram_arvalid, sram_rready, sram_awvalid;
    logic        sram_wvalid, sram_bready;
    logic [31:0] ifu_rdata, lsu_rdata, sram_araddr, sram_awaddr, sram_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, grant_rr;
    logic [3:0]  sram_wstrb;

    // Fixed-priority instance outputs
    logic        fp_ifu_arready, fp_ifu_rvalid, fp_lsu_arready, fp_lsu_rvalid;
    logic        fp_lsu_awready, fp_lsu_wready, fp_lsu_bvalid, fp_sram_arvalid;
    logic        fp_sram_rready, fp_sram_awvalid, fp_sram_wvalid, fp_sram_bready;
    logic [31:0] fp_ifu_rdata, fp_lsu_rdata, fp_sram_araddr, fp_sram_awaddr, fp_sram_wdata;
    logic [1:0]  fp_ifu_rresp, fp_lsu_rresp, fp_lsu_bresp, grant_fp;
    logic [3:0]  fp_sram_wstrb;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
        .lsu_bready(lsu_bready),
        .sram_araddr(sram_araddr), .sram_arvalid(sram_arvalid), .sram_arready(sram_arready),
        .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rvalid(sram_rvalid),
        .sram_rready(sram_rready),
        .sram_awaddr(sram_awaddr), .sram_awvalid(sram_awvalid), .sram_awready(sram_awready),
        .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_wvalid(sram_wvalid),
        .sram_wready(sram_wready), .sram_bresp(sram_bresp), .sram_bvalid(sram_bvalid),
        .sram_bready(sram_bready),
        .grant(grant_rr)
    );

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(fp_ifu_arready),
        .ifu_rdata(fp_ifu_rdata), .ifu_rresp(fp_ifu_rresp), .ifu_rvalid(fp_ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(fp_lsu_arready),
        .lsu_rdata(fp_lsu_rdata), .lsu_rresp(fp_lsu_rresp), .lsu_rvalid(fp_lsu_rvalid),
        .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(fp_lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(fp_lsu_wready), .lsu_bresp(fp_lsu_bresp), .lsu_bvalid(fp_lsu_bvalid),
        .lsu_bready(lsu_bready),
        .sram_araddr(fp_sram_araddr), .sram_arvalid(fp_sram_arvalid),
        .sram_arready(sram_arready),
        .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rvalid(sram_rvalid),
        .sram_rready(fp_sram_rready),
        .sram_awaddr(fp_sram_awaddr), .sram_awvalid(fp_sram_awvalid),
        .sram_awready(sram_awready),
        .sram_wdata(fp_sram_wdata), .sram_wstrb(fp_sram_wstrb), .sram_wvalid(fp_sram_wvalid),
        .sram_wready(sram_wready), .sram_bresp(sram_bresp), .sram_bvalid(sram_bvalid),
        .sram_bready(fp_sram_bready),
        .grant(grant_fp)
    );

    // Handshake view of the round-robin instance:
    // {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
    //  lsu_bvalid, sram_arvalid, sram_rready, sram_awvalid, sram_wvalid, sram_bready}
    logic [11:0] rr_outs;
    assign rr_outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready,
                      lsu_wready, lsu_bvalid, sram_arvalid, sram_rready, sram_awvalid,
                      sram_wvalid, sram_bready};

    typedef struct {
        string      name;
        logic [11:0] stim;
        logic [1:0]  g_rr;
        logic [1:0]  g_fp;
        logic [11:0] outs;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0]  g_rr;
        logic [1:0]  g_fp;
        logic [11:0] outs;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    logic [31:0] data_q[$];
    int          n_checks;
    int          n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // stim = {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid,
    //         sram_arready, sram_rvalid, sram_awready, sram_wready, sram_bvalid,
    //         ifu_rready, lsu_rready, lsu_bready}
    task automatic apply(input logic [11:0] stim);
        {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, sram_arready, sram_rvalid,
         sram_awready, sram_wready, sram_bvalid, ifu_rready, lsu_rready, lsu_bready} = stim;
    endtask

    task automatic add(input string name, input logic [11:0] stim, input logic [1:0] g_rr,
                       input logic [1:0] g_fp, input logic [11:0] outs);
        vec_t v;
        v.name = name; v.stim = stim; v.g_rr = g_rr; v.g_fp = g_fp; v.outs = outs;
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input string name, input logic [1:0] g_rr,
                                input logic [1:0] g_fp);
        chk({name, "_grant_rr"}, grant_rr, g_rr);
        chk({name, "_grant_fp"}, grant_fp, g_fp);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] d;
        n_checks = 0;
        n_errors = 0;

        // Vector table
        add("reset_idle",     12'b000_0_00000_000, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("ifu_req",        12'b100_0_00000_000, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("ifu_ar_wait1",   12'b100_0_00000_000, 2'b01, 2'b01, 12'b00_00_000_10000);
        add("ifu_ar_wait2",   12'b100_0_00000_000, 2'b01, 2'b01, 12'b00_00_000_10000);
        add("ifu_ar_hs",      12'b100_0_10000_000, 2'b01, 2'b01, 12'b10_00_000_10000);
        add("ifu_r_hs",       12'b000_0_01000_110, 2'b01, 2'b01, 12'b01_00_000_01000);
        add("ifu_done",       12'b000_0_00000_000, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("tie_idle0",      12'b110_0_11000_110, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("tie_1",          12'b110_0_11000_110, 2'b10, 2'b10, 12'b00_11_000_11000);
        add("tie_idle1",      12'b110_0_11000_110, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("tie_2",          12'b110_0_11000_110, 2'b01, 2'b10, 12'b11_00_000_11000);
        add("tie_idle2",      12'b110_0_11000_110, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("tie_3",          12'b110_0_11000_110, 2'b10, 2'b10, 12'b00_11_000_11000);
        add("tie_idle3",      12'b110_0_11000_110, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("tie_4",          12'b110_0_11000_110, 2'b01, 2'b10, 12'b11_00_000_11000);
        add("lsu_drop_idle",  12'b100_0_11000_110, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("lsu_drop_ifu",   12'b100_0_11000_110, 2'b01, 2'b01, 12'b11_00_000_11000);
        add("idle_a",         12'b000_0_00000_000, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("wr_req",         12'b001_1_00010_000, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("wr_w_first",     12'b001_1_00010_000, 2'b11, 2'b11, 12'b00_00_010_00110);
        add("wr_aw_hs",       12'b001_0_00110_000, 2'b11, 2'b11, 12'b00_00_110_00100);
        add("wr_b_wait",      12'b000_0_00001_000, 2'b11, 2'b11, 12'b00_00_001_00000);
        add("wr_b_hs",        12'b000_0_00001_001, 2'b11, 2'b11, 12'b00_00_001_00001);
        add("wr_done",        12'b000_0_00000_000, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("rw_idle",        12'b011_1_11111_111, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("rw_read_wins",   12'b011_1_11111_111, 2'b10, 2'b10, 12'b00_11_000_11000);
        add("wr_after_idle",  12'b001_1_11111_111, 2'b00, 2'b00, 12'b00_00_000_00000);
        add("wr_one_cycle",   12'b001_1_11111_111, 2'b11, 2'b11, 12'b00_00_111_00111);
        add("idle_b",         12'b000_0_00000_000, 2'b00, 2'b00, 12'b00_00_000_00000);

        ifu_araddr = 32'h8000_0000;
        lsu_araddr = 32'h8000_0200;
        lsu_awaddr = 32'h8000_0100;
        lsu_wdata  = 32'hDEAD_BEEF;
        lsu_wstrb  = 4'b1111;
        sram_rdata = 32'h0000_0413;
        sram_rresp = 2'b00;
        sram_bresp = 2'b00;
        apply(12'b0);

        // Reset held across edges: outputs idle
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_grants("in_reset", 2'b00, 2'b00);
        chk("in_reset_outs", rr_outs, 12'b0);
        step();
        reset = 1'b1;

        foreach (vecs[i]) begin
            step();
            apply(vecs[i].stim);
            e.name = vecs[i].name;
            e.g_rr = vecs[i].g_rr;
            e.g_fp = vecs[i].g_fp;
            e.outs = vecs[i].outs;
            exp_q.push_back(e);
            #1;
            e = exp_q.pop_front();
            check_grants(e.name, e.g_rr, e.g_fp);
            chk({e.name, "_outs"}, rr_outs, e.outs);
        end

        // LSU read, SLVERR response, master stalls rready 3 cycles while IFU waits
        step();
        apply(12'b010_0_00000_000);
        #1;
        check_grants("lrd_req", 2'b00, 2'b00);
        step();
        apply(12'b110_0_10000_000);
        #1;
        check_grants("lrd_ar", 2'b10, 2'b10);
        chk("lrd_araddr", sram_araddr, 32'h8000_0200);
        chk("lrd_arready", {lsu_arready, ifu_arready}, 2'b10);
        sram_rdata = 32'h1234_5678;
        sram_rresp = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step();
            apply((k == 3) ? 12'b100_0_01000_010 : 12'b100_0_01000_000);
            data_q.push_back(32'h1234_5678);
            #1;
            d = data_q.pop_front();
            check_grants($sformatf("lrd_stall%0d", k), 2'b10, 2'b10);
            chk($sformatf("lrd_rdata%0d", k), lsu_rdata, d);
            chk($sformatf("lrd_rresp%0d", k), lsu_rresp, 2'b10);
            chk($sformatf("lrd_rv%0d", k), {lsu_rvalid, ifu_rvalid, ifu_arready}, 3'b100);
            chk($sformatf("lrd_rready%0d", k), sram_rready, (k == 3) ? 1'b1 : 1'b0);
        end
        step();
        apply(12'b100_0_00000_000);
        #1;
        check_grants("lrd_exit", 2'b00, 2'b00);
        chk("lrd_exit_outs", rr_outs, 12'b0);

        // Waiting IFU read now served
        sram_rdata = 32'h0000_0413;
        sram_rresp = 2'b00;
        step();
        apply(12'b100_0_11000_100);
        data_q.push_back(32'h0000_0413);
        #1;
        d = data_q.pop_front();
        check_grants("ird_after", 2'b01, 2'b01);
        chk("ird_after_araddr", sram_araddr, 32'h8000_0000);
        chk("ird_after_rdata", ifu_rdata, d);
        chk("ird_after_lsu_quiet", {lsu_arready, lsu_rvalid}, 2'b00);
        step();
        apply(12'b0);
        #1;
        check_grants("ird_after_exit", 2'b00, 2'b00);

        // LSU store, reset after AW handshake but before B
        step();
        apply(12'b001_1_00000_000);
        #1;
        check_grants("sw_req", 2'b00, 2'b00);
        step();
        apply(12'b001_1_00100_000);
        #1;
        check_grants("sw_aw", 2'b11, 2'b11);
        chk("sw_awaddr", sram_awaddr, 32'h8000_0100);
        chk("sw_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk("sw_wstrb", sram_wstrb, 4'b1111);
        chk("sw_ready", {lsu_awready, lsu_wready}, 2'b10);
        step();
        apply(12'b000_1_00011_001);
        #1;
        chk("sw_pre_reset_grant", grant_rr, 2'b11);
        reset = 1'b0;
        #1;
        check_grants("sw_reset", 2'b00, 2'b00);
        chk("sw_reset_outs", rr_outs, 12'b0);
        chk("sw_reset_data", {sram_wdata, sram_wstrb}, 36'h0);
        chk("sw_reset_addr", sram_awaddr, 32'h0);
        step();
        check_grants("sw_reset_hold", 2'b00, 2'b00);
        reset = 1'b1;
        apply(12'b100_0_00000_000);
        #1;
        check_grants("post_rst_req", 2'b00, 2'b00);
        step();
        apply(12'b100_0_10000_000);
        #1;
        check_grants("post_rst_ar", 2'b01, 2'b01);
        chk("post_rst_arready", ifu_arready, 1'b1);
        step();
        apply(12'b000_0_01000_100);
        data_q.push_back(32'h0000_0413);
        #1;
        d = data_q.pop_front();
        chk("post_rst_rdata", ifu_rdata, d);
        chk("post_rst_rvalid", ifu_rvalid, 1'b1);
        step();
        apply(12'b0);
        #1;
        check_grants("post_rst_exit", 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared SRAM AXI4-Lite-style bus.
- IFU is a read-only master. LSU (MEM stage) is a read/write master.
- Sequences exactly one outstanding transaction at a time.
- Grant is held from address handshake to response handshake; all five channels are routed to the granted master.
- Sits between the IFU/LSU bus ports and the SRAM/SoC slave port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width = DATA_W/8)
RR_EN, 1, 1 = round-robin between masters on simultaneous request; 0 = fixed LSU priority

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
ifu_araddr/ifu_arvalid  in  ADDR_W/1  IFU AR channel; ifu_arready out 1
ifu_rdata/ifu_rresp/ifu_rvalid  out  DATA_W/2/1  IFU R channel; ifu_rready in 1
lsu_araddr/lsu_arvalid  in  ADDR_W/1  LSU AR channel; lsu_arready out 1
lsu_rdata/lsu_rresp/lsu_rvalid  out  DATA_W/2/1  LSU R channel; lsu_rready in 1
lsu_awaddr/lsu_awvalid  in  ADDR_W/1  LSU AW channel; lsu_awready out 1
lsu_wdata/lsu_wstrb/lsu_wvalid  in  DATA_W/DATA_W/8/1  LSU W channel; lsu_wready out 1
lsu_bresp/lsu_bvalid  out  2/1  LSU B channel; lsu_bready in 1
sram_araddr/sram_arvalid  out  ADDR_W/1  slave AR; sram_arready in 1
sram_rdata/sram_rresp/sram_rvalid  in  DATA_W/2/1  slave R; sram_rready out 1
sram_awaddr/sram_awvalid  out  ADDR_W/1  slave AW; sram_awready in 1
sram_wdata/sram_wstrb/sram_wvalid  out  DATA_W/DATA_W/8/1  slave W; sram_wready in 1
sram_bresp/sram_bvalid  in  2/1  slave B; sram_bready out 1
grant  out  2  debug: 00 none, 01 IFU read, 10 LSU read, 11 LSU write

Behaviour:
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. Reset (reset==0, async) forces IDLE and last_grant=IFU (LSU wins the first tie).
- IDLE:
  - All master-side ready/valid outputs are 0. All sram_* valid/ready outputs are 0. All routed data/addr outputs are 0.
  - Requests sampled each cycle: ifu_arvalid, lsu_arvalid, lsu_awvalid.
- Arbitration, registered (one cycle from request to grant):
  - LSU vs IFU tie: RR_EN=1 grants the master not granted last; RR_EN=0 always grants LSU.
  - lsu_arvalid and lsu_awvalid together: LSU read wins.
  - Next state is IFU_RD, LSU_RD or LSU_WR. last_grant updates on entry.
- Granted state: pure combinational pass-through of the relevant channels between the granted master and the sram_* port. No added latency.
  - Ungranted master: all ready/valid outputs 0.
  - Unused slave channels: valid/ready 0.
  - IFU_RD/LSU_RD: AR and R routed. Exit to IDLE on the cycle after sram_rvalid && granted rready.
  - LSU_WR: AW, W and B routed. AW and W may handshake in either order or the same cycle. Exit to IDLE on the cycle after sram_bvalid && lsu_bready.
- Grant is never revoked mid-transaction. Masters deasserting valid after grant is illegal; the arbiter waits indefinitely.
- rresp/bresp pass through unmodified; SLVERR/DECERR are not masked.
- A request arriving in the exit cycle is arbitrated in IDLE the following cycle. Minimum back-to-back spacing: one IDLE cycle.
- grant mirrors the state encoding. It is 00 in IDLE and during reset.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The slave is expected to be reset by the same signal.
- Assertions (sim only):
  - no sram handshake in IDLE;
  - no R handshake in LSU_WR;
  - no B handshake in a read state.

Test Plan:
- IFU read alone, araddr=0x8000_0000, slave arready after 2 cycles, rdata=0x0000_0413 rresp=OKAY -> grant=01 one cycle after arvalid; ifu_rdata=0x0000_0413; back to IDLE; lsu_* ready/valid stay 0.
- LSU sw: awaddr=0x8000_0100, wdata=0xDEAD_BEEF, wstrb=4'b1111, W before AW accepted -> grant=11; sram_wstrb=1111; lsu_bvalid follows sram_bvalid; IDLE after B handshake.
- IFU and LSU read both asserted every cycle, RR_EN=1 -> grants alternate LSU, IFU, LSU, IFU. RR_EN=0 -> LSU every time until lsu_arvalid drops.
- LSU read with sram_rresp=2'b10 -> lsu_rresp=2'b10 same cycle; ifu_rvalid stays 0; IDLE next cycle.
- Assert reset=0 during LSU_WR after the AW handshake, before B -> grant=00 and all valid/ready outputs 0 immediately; after release, a new IFU read completes normally.
- Slave holds rvalid while lsu_rready=0 for 3 cycles -> state stays LSU_RD; rdata stable; no IFU grant until the handshake completes.
